// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with occupancy count,
// almost-full/almost-empty thresholds and overflow/underflow error pulses.
// Optional feature macro: FIFO_FWFT_EN (first-word fall-through read port).
// Without the macro, data_out is registered with one cycle of read latency.
module sync_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     w_en,
  input  logic                     r_en,
  input  logic [DATA_WIDTH-1:0]    data_in,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE     = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] FULL_C  = DEPTH[AW:0];
  localparam logic [AW:0] AF_C    = AF_THRESH[AW:0];
  localparam logic [AW:0] AE_C    = AE_THRESH[AW:0];

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr, rd_ptr, cnt_nxt;
  logic                  wr_acc, rd_acc;

  // Accept/reject decisions and next occupancy; a full FIFO still takes a
  // write when a read frees a slot in the same cycle.
  always_comb begin
    wr_acc  = 1'b0;
    rd_acc  = 1'b0;
    cnt_nxt = count;
    rd_acc  = r_en & ~empty;
    wr_acc  = w_en & (~full | r_en);
    case ({wr_acc, rd_acc})
      2'b10:   cnt_nxt = count + ONE;
      2'b01:   cnt_nxt = count - ONE;
      default: cnt_nxt = count;
    endcase
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr[AW-1:0]] <= data_in;
  end

  // Pointers, count, registered flags and error pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ONE;
      if (rd_acc) rd_ptr <= rd_ptr + ONE;
      count        <= cnt_nxt;
      full         <= (cnt_nxt == FULL_C);
      empty        <= (cnt_nxt == '0);
      almost_full  <= (cnt_nxt >= AF_C);
      almost_empty <= (cnt_nxt <= AE_C);
      overflow     <= w_en & ~wr_acc;
      underflow    <= r_en & ~rd_acc;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head entry visible combinationally; zero when nothing is stored.
  assign data_out = empty ? '0 : mem[rd_ptr[AW-1:0]];
`else
  // Registered read port: data_out updates on the popping edge, else holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        data_out <= '0;
    else if (rd_acc) data_out <= mem[rd_ptr[AW-1:0]];
  end
`endif

  // The wrap-bit pointer distance must always equal the occupancy count.
  a_ptr_count: assert property (@(posedge clk) disable iff (!rst)
    (wr_ptr - rd_ptr) == count);

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: table-driven fill/drain vectors,
// queue scoreboard for read data, and hand sequences for the corner cases.
module tb_sync_fifo_param;
  logic       clk = 1'b0;
  logic       rst;
  logic       w_en, r_en;
  logic [7:0] data_in, data_out;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] count;

  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0] model_q[$];

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .w_en(w_en), .r_en(r_en), .data_in(data_in),
    .data_out(data_out), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow),
    .underflow(underflow)
  );

  typedef struct {
    logic       w, r;
    logic [7:0] d, xdata;
    logic [3:0] xcnt;
    logic       xfull, xempty, xaf, xae, xovf, xunf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One clock of stimulus. Called #1 after a rising edge; returns #1 after the
  // next one. Read data is sampled before the edge in FWFT mode, after it otherwise.
  task automatic step(input logic w, input logic r, input logic [7:0] d, output logic [7:0] rd);
    logic       wacc, racc;
    logic [7:0] head;
    int         mc;
    mc   = model_q.size();
    racc = r && (mc != 0);
    wacc = w && ((mc != 8) || r);
    head = (mc != 0) ? model_q[0] : 8'h00;
    w_en = w; r_en = r; data_in = d; rd = 8'h00;
`ifdef FIFO_FWFT_EN
    @(negedge clk); rd = data_out;
`endif
    @(posedge clk); #1;
`ifndef FIFO_FWFT_EN
    rd = data_out;
`endif
    if (racc) begin
      void'(model_q.pop_front());
      check("sb_data", 32'(rd), 32'(head));
    end
    if (wacc) model_q.push_back(d);
    mc = model_q.size();
    check("sb_count", 32'(count), 32'(mc));
    check("sb_full",  32'(full),  32'(mc == 8));
    check("sb_empty", 32'(empty), 32'(mc == 0));
    check("sb_af",    32'(almost_full),  32'(mc >= 6));
    check("sb_ae",    32'(almost_empty), 32'(mc <= 2));
    check("sb_ovf",   32'(overflow),  32'(w && !wacc));
    check("sb_unf",   32'(underflow), 32'(r && !racc));
    w_en = 1'b0; r_en = 1'b0;
  endtask

  vec_t tbl[20];
  logic [7:0] rd;

  initial begin
    // w r d xdata cnt full empty af ae ovf unf
    tbl[0]  = '{1'b1,1'b0,8'h11,8'h00,4'd1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0};
    tbl[1]  = '{1'b1,1'b0,8'h22,8'h00,4'd2,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0};
    tbl[2]  = '{1'b1,1'b0,8'h33,8'h00,4'd3,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    tbl[3]  = '{1'b1,1'b0,8'h44,8'h00,4'd4,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    tbl[4]  = '{1'b1,1'b0,8'h55,8'h00,4'd5,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    tbl[5]  = '{1'b1,1'b0,8'h66,8'h00,4'd6,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0};
    tbl[6]  = '{1'b1,1'b0,8'h77,8'h00,4'd7,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0};
    tbl[7]  = '{1'b1,1'b0,8'h88,8'h00,4'd8,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0};
    tbl[8]  = '{1'b1,1'b0,8'h99,8'h00,4'd8,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0};
    tbl[9]  = '{1'b0,1'b0,8'h00,8'h00,4'd8,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0};
    tbl[10] = '{1'b0,1'b1,8'h00,8'h11,4'd7,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0};
    tbl[11] = '{1'b0,1'b1,8'h00,8'h22,4'd6,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0};
    tbl[12] = '{1'b0,1'b1,8'h00,8'h33,4'd5,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    tbl[13] = '{1'b0,1'b1,8'h00,8'h44,4'd4,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    tbl[14] = '{1'b0,1'b1,8'h00,8'h55,4'd3,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    tbl[15] = '{1'b0,1'b1,8'h00,8'h66,4'd2,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0};
    tbl[16] = '{1'b0,1'b1,8'h00,8'h77,4'd1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0};
    tbl[17] = '{1'b0,1'b1,8'h00,8'h88,4'd0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0};
    tbl[18] = '{1'b0,1'b1,8'h00,8'h00,4'd0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1};
    tbl[19] = '{1'b0,1'b0,8'h00,8'h00,4'd0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0};

    // Reset held with request activity: everything stays in reset state.
    rst = 1'b0; w_en = 1'b0; r_en = 1'b0; data_in = 8'h00;
    for (int i = 0; i < 3; i++) begin
      w_en = i[0]; r_en = !i[0]; data_in = 8'hE0 + 8'(i);
      @(posedge clk); #1;
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_count", 32'(count), 32'd0);
      check("rst_dout",  32'(data_out), 32'd0);
      check("rst_full",  32'(full), 32'd0);
      check("rst_ae",    32'(almost_empty), 32'd1);
      check("rst_af",    32'(almost_full), 32'd0);
      check("rst_ovf",   32'(overflow), 32'd0);
      check("rst_unf",   32'(underflow), 32'd0);
    end
    w_en = 1'b0; r_en = 1'b0; rst = 1'b1;
    step(1'b0, 1'b0, 8'h00, rd);
    step(1'b0, 1'b0, 8'h00, rd);
    check("idle_dout", 32'(data_out), 32'd0);

    // Fill, overflow, drain, underflow from the vector table.
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].w, tbl[i].r, tbl[i].d, rd);
      check($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].xcnt));
      check($sformatf("tbl%0d_full", i),  32'(full),  32'(tbl[i].xfull));
      check($sformatf("tbl%0d_empty", i), 32'(empty), 32'(tbl[i].xempty));
      check($sformatf("tbl%0d_af", i),    32'(almost_full),  32'(tbl[i].xaf));
      check($sformatf("tbl%0d_ae", i),    32'(almost_empty), 32'(tbl[i].xae));
      check($sformatf("tbl%0d_ovf", i),   32'(overflow),  32'(tbl[i].xovf));
      check($sformatf("tbl%0d_unf", i),   32'(underflow), 32'(tbl[i].xunf));
      if (tbl[i].r && !tbl[i].xunf)
        check($sformatf("tbl%0d_data", i), 32'(rd), 32'(tbl[i].xdata));
    end

    // Simultaneous read+write at full: both accepted, 0xAA comes out last.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'hA0 + 8'(i), rd);
    step(1'b1, 1'b1, 8'hAA, rd);
    check("simfull_count", 32'(count), 32'd8);
    check("simfull_ovf",   32'(overflow), 32'd0);
    check("simfull_data",  32'(rd), 32'hA0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00, rd);
    check("simfull_last", 32'(rd), 32'hAA);

    // Simultaneous read+write at empty: write only, underflow pulse.
    step(1'b1, 1'b1, 8'h55, rd);
    check("simempty_count", 32'(count), 32'd1);
    check("simempty_unf",   32'(underflow), 32'd1);
    step(1'b0, 1'b1, 8'h00, rd);
    check("simempty_data",  32'(rd), 32'h55);

    // Pointer wrap with writes leading reads by three.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'($urandom), rd);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 8'($urandom), rd);
      step(1'b0, 1'b1, 8'h00, rd);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00, rd);
    check("wrap_empty", 32'(empty), 32'd1);

    // Asynchronous reset with five entries stored.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'hC0 + 8'(i), rd);
    #2 rst = 1'b0;
    #1;
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_empty", 32'(empty), 32'd1);
    check("midrst_full",  32'(full), 32'd0);
    model_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    step(1'b1, 1'b0, 8'h3C, rd);
    step(1'b0, 1'b1, 8'h00, rd);
    check("midrst_data", 32'(rd), 32'h3C);
    step(1'b0, 1'b0, 8'h00, rd);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
